// File: rtl/adc128s022_spi_responder.sv
// adc128s022_spi_responder
// SPI responder that behaves like an ADC128S022 (8 channels, 12 bits).
// Each 16-SCK frame captures a 3-bit channel address from MOSI and returns
// four leading zeros followed by a 12-bit sample on MISO. The address
// received in one frame selects the sample returned in the next frame.
// All SPI pins are oversampled by clk, so clk must run at >= 8x SCK.
//
// Optional feature: define ADC_EMU_MISO_OE_EN to add the spi_miso_oe output.
// That output is high only while a frame is active, so a pad can tri-state MISO.
module adc128s022_spi_responder #(
  parameter int SYNC_STAGES = 2,  // 2..3 synchronizer flops per pin
  parameter int RESET_CH    = 0   // channel returned in the first frame
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [95:0] ch_data,
  output logic        frame_done,
  output logic        frame_err,
`ifdef ADC_EMU_MISO_OE_EN
  output logic        spi_miso_oe,
`endif
  output logic [2:0]  last_addr
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_END    = 2'd3
  } state_t;

  // Number of SCK rising edges that make a complete frame, and the
  // saturation value of the rising-edge counter.
  localparam logic [4:0] FULL_FRAME = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  // ---------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  // Shift each pin through its synchronizer chain. The chains reset to 0 so
  // that a CS held low across reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Keep a one-clock delayed copy of the synced SCK and CS for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b0;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // ---------------------------------------------------------------------
  // Channel sample selection
  // ---------------------------------------------------------------------
  logic [11:0] ch_word [8];
  logic [2:0]  cur_ch;
  logic [11:0] cur_sample;

  for (genvar g = 0; g < 8; g++) begin : g_ch_split
    assign ch_word[g] = ch_data[12*g +: 12];
  end

  assign cur_sample = ch_word[cur_ch];

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [15:0] sr;
  logic [4:0]  rise_cnt;
  logic [2:0]  addr_sr;

  logic frame_ok;
  logic start_frame;
  logic do_rise;
  logic do_fall;
  logic addr_bit;
  logic done_nxt;
  logic err_nxt;
  logic oe_nxt;

  assign frame_ok = (rise_cnt >= FULL_FRAME);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a CS rising edge ends the frame regardless of SCK.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT: begin
        if (cs_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_IDLE: begin
        if (cs_fall) begin
          state_nxt = S_ACTIVE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          state_nxt = S_END;
        end else begin
          state_nxt = S_ACTIVE;
        end
      end
      S_END: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

  // Output/event decode. Pulse flags are computed on the transition into
  // S_END so that their registered copies are high exactly during S_END.
  always_comb begin
    start_frame = 1'b0;
    do_rise     = 1'b0;
    do_fall     = 1'b0;
    addr_bit    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    oe_nxt      = (state_nxt == S_ACTIVE);
    case (state)
      S_IDLE: begin
        start_frame = cs_fall;
      end
      S_ACTIVE: begin
        if (cs_rise) begin
          done_nxt = frame_ok;
          err_nxt  = ~frame_ok;
        end else begin
          do_rise  = sck_rise;
          // Falling edges before the first rising edge are ignored, so a
          // master idling SCK high does not shift out a bit early.
          do_fall  = sck_fall & (rise_cnt != 5'd0);
          addr_bit = sck_rise & (rise_cnt >= 5'd2) & (rise_cnt <= 5'd4);
        end
      end
      default: begin
        start_frame = 1'b0;
      end
    endcase
  end

  // Frame datapath: snapshot, MOSI address capture and MISO shifting.
  // spi_miso is the MSB of sr; sr is zero outside an active frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= 16'h0000;
      rise_cnt  <= 5'd0;
      addr_sr   <= 3'd0;
      cur_ch    <= 3'(RESET_CH);
      last_addr <= 3'd0;
    end else begin
      if (start_frame) begin
        sr       <= {4'h0, cur_sample};
        rise_cnt <= 5'd0;
        addr_sr  <= 3'd0;
      end else if (state == S_END) begin
        sr <= 16'h0000;
        if (frame_ok) begin
          cur_ch    <= addr_sr;
          last_addr <= addr_sr;
        end
      end else begin
        if (do_rise && (rise_cnt != CNT_SAT)) begin
          rise_cnt <= rise_cnt + 5'd1;
        end
        if (addr_bit) begin
          addr_sr <= {addr_sr[1:0], mosi_s};
        end
        if (do_fall) begin
          sr <= {sr[14:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso = sr[15];

  // Registered frame status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
    end
  end

`ifdef ADC_EMU_MISO_OE_EN
  // MISO output enable, high only while the FSM is in S_ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= oe_nxt;
    end
  end
`else
  logic oe_unused;
  assign oe_unused = oe_nxt;
`endif

endmodule

// File: tb/tb_adc128s022_spi_responder.sv
// Testbench for adc128s022_spi_responder: acts as an SPI master at 1 MHz
// SCK with a 50 MHz system clock and compares MISO words, frame pulses and
// last_addr against a channel-level model of the emulated ADC.
module tb_adc128s022_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int RESET_CH    = 0;

  logic        clk;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [95:0] ch_data;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  last_addr;
`ifdef ADC_EMU_MISO_OE_EN
  logic        spi_miso_oe;
`endif

  adc128s022_spi_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_CH    (RESET_CH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .ch_data     (ch_data),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
`ifdef ADC_EMU_MISO_OE_EN
    .spi_miso_oe (spi_miso_oe),
`endif
    .last_addr   (last_addr)
  );

  // 50 MHz system clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Count clocks with frame_done / frame_err high, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  // Model: the channel values, the channel the next frame returns and the
  // address of the last complete frame.
  logic [11:0] chan [8];
  int          model_ch;
  logic [2:0]  model_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_channels();
    for (int i = 0; i < 8; i++) ch_data[12*i +: 12] = chan[i];
  endtask

  task automatic randomize_channels();
    for (int i = 0; i < 8; i++) chan[i] = 12'($urandom);
    drive_channels();
  endtask

  // One SPI transaction: MOSI carries {2'b00, addr, 11'b0}, MISO is sampled
  // just before each SCK rising edge. Optionally rewrites ch_data mid-frame.
  task automatic run_frame(input logic [2:0] addr, input int n_rise, input bit mid_change,
                           output logic [15:0] rx);
    logic [15:0] din;
    din = {2'b00, addr, 11'b0};
    rx = 16'h0000;
    spi_cs_n = 1'b0;
    for (int i = 0; i < n_rise; i++) begin
      spi_mosi = din[15-i];
      #500;
      rx = {rx[14:0], spi_miso};
      spi_sck = 1'b1;
      #500;
      spi_sck = 1'b0;
      if (mid_change && i == 6) randomize_channels();
    end
    #500;
    spi_cs_n = 1'b1;
    #500;
  endtask

  task automatic full_frame(input logic [2:0] addr, input bit mid_change);
    logic [15:0] exp_w;
    logic [15:0] rx;
    int d0, e0;
    exp_w = {4'h0, chan[model_ch]};
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(addr, 16, mid_change, rx);
    check("miso_word", 32'(rx), 32'(exp_w));
    check("done_pulse", 32'(done_cnt - d0), 32'd1);
    check("err_quiet", 32'(err_cnt - e0), 32'd0);
    model_ch   = int'(addr);
    model_last = addr;
    check("last_addr", 32'(last_addr), 32'(model_last));
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] exp_w;
    int d0, e0;

    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    randomize_channels();
    model_ch   = RESET_CH;
    model_last = 3'd0;
    #103;
    rst = 1'b0;
    #400;

    // Reset state.
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_last_addr", 32'(last_addr), 32'd0);

    // First frame returns ch0; address 1 selects ch1 for the next frame.
    chan[0] = 12'hA5C;
    drive_channels();
    full_frame(3'd1, 1'b0);

    // Pipelined address: ch1 comes back now, then ch0.
    chan[1] = 12'h3F0;
    drive_channels();
    full_frame(3'd0, 1'b0);
    full_frame(3'd5, 1'b0);

    // Random channel data and addresses.
    for (int k = 0; k < 8; k++) begin
      randomize_channels();
      full_frame(3'($urandom_range(0, 7)), 1'b0);
    end

    // Aborted frame after 8 rising edges: error pulse, selection kept.
    exp_w = {4'h0, chan[model_ch]};
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(3'($urandom_range(0, 7)), 8, 1'b0, rx);
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_partial", 32'(rx[7:0]), 32'(exp_w[15:8]));
    check("abort_last_addr", 32'(last_addr), 32'(model_last));
    full_frame(3'($urandom_range(0, 7)), 1'b0);

    // ch_data changing mid-frame does not affect the word being sent.
    full_frame(3'($urandom_range(0, 7)), 1'b1);

    // SCK toggling with CS high is ignored.
    d0 = done_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 10; k++) begin
      spi_sck = 1'b1;
      #100;
      spi_sck = 1'b0;
      #100;
      check("cs_high_miso", 32'(spi_miso), 32'd0);
    end
    check("cs_high_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    full_frame(3'($urandom_range(0, 7)), 1'b0);

    // Reset in the middle of a frame with CS held low.
    d0 = done_cnt;
    e0 = err_cnt;
    spi_cs_n = 1'b0;
    #500;
    for (int k = 0; k < 5; k++) begin
      spi_sck = ~spi_sck;
      #500;
    end
    rst = 1'b1;
    #200;
    spi_sck = 1'b0;
    rst = 1'b0;
    #500;
    model_ch   = RESET_CH;
    model_last = 3'd0;
    check("midrst_miso", 32'(spi_miso), 32'd0);
    check("midrst_last_addr", 32'(last_addr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      spi_sck = ~spi_sck;
      #500;
    end
    spi_sck = 1'b0;
    #500;
    spi_cs_n = 1'b1;
    #1000;
    check("midrst_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    randomize_channels();
    full_frame(3'($urandom_range(0, 7)), 1'b0);

`ifdef ADC_EMU_MISO_OE_EN
    // Output enable timing around a CS falling edge and an abort.
    check("oe_idle", 32'(spi_miso_oe), 32'd0);
    e0 = err_cnt;
    @(posedge clk);
    #1;
    spi_cs_n = 1'b0;
    for (int k = 0; k < SYNC_STAGES; k++) @(posedge clk);
    @(negedge clk);
    check("oe_early", 32'(spi_miso_oe), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("oe_on", 32'(spi_miso_oe), 32'd1);
    #500;
    check("oe_held", 32'(spi_miso_oe), 32'd1);
    spi_cs_n = 1'b1;
    #500;
    check("oe_off", 32'(spi_miso_oe), 32'd0);
    check("oe_abort_err", 32'(err_cnt - e0), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
